// File: rtl/comparator_swap_pipe_if.sv
// ---------------------------------------------------------------------------
// comparator_swap_pipe_if
//   Handshake and data bundle for comparator_swap_pipe.
//   Input side : in_valid/in_ready with operands Data_A/Data_B.
//   Output side: out_valid/out_ready with less/equal/greater/swap flags,
//                max_out/min_out and, when CMP_SWAP_DIFF_EN is defined,
//                diff_out.
//   Modports:
//     slave  - the comparator's view (consumes operands, produces results)
//     master - the surrounding datapath's view
// ---------------------------------------------------------------------------
interface comparator_swap_pipe_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Data_A;
    logic [W-1:0] Data_B;
    logic         out_valid;
    logic         out_ready;
    logic         less;
    logic         equal;
    logic         greater;
    logic         swap;
    logic [W-1:0] max_out;
    logic [W-1:0] min_out;
`ifdef CMP_SWAP_DIFF_EN
    logic [W-1:0] diff_out;

    modport slave (
        input  in_valid, Data_A, Data_B, out_ready,
        output in_ready, out_valid, less, equal, greater, swap,
               max_out, min_out, diff_out
    );

    modport master (
        output in_valid, Data_A, Data_B, out_ready,
        input  in_ready, out_valid, less, equal, greater, swap,
               max_out, min_out, diff_out
    );
`else
    modport slave (
        input  in_valid, Data_A, Data_B, out_ready,
        output in_ready, out_valid, less, equal, greater, swap,
               max_out, min_out
    );

    modport master (
        output in_valid, Data_A, Data_B, out_ready,
        input  in_ready, out_valid, less, equal, greater, swap,
               max_out, min_out
    );
`endif
endinterface

// File: rtl/comparator_swap_pipe.sv
// ---------------------------------------------------------------------------
// comparator_swap_pipe
//   Two-stage elastic magnitude comparator with operand swap for the FP
//   add/sub datapath. Results present the larger operand first so the
//   exponent-align stage receives max/min directly.
//
// Parameters
//   W     operand width (>= 2)
//   MODE  0 = unsigned, 1 = two's complement, 2 = sign-magnitude (MSB sign)
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset; discards both stages
//   bus  comparator_swap_pipe_if.slave
//          in_valid/in_ready/Data_A/Data_B       operand handshake
//          out_valid/out_ready                   result handshake
//          less/equal/greater/swap               one-hot relation, swap==less
//          max_out/min_out                       raw patterns, A first on tie
//          diff_out                              max - min magnitude
//                                                (CMP_SWAP_DIFF_EN only)
//
// Optional feature macro: CMP_SWAP_DIFF_EN builds the stage-2 subtractor and
// the diff_out port. Undefined, no subtractor exists.
//
// Latency is two cycles accept-to-out_valid, throughput one per cycle; the
// input side is ready whenever stage 1 is empty or is moving into stage 2
// this cycle (combinational from out_ready, no skid buffer).
// ---------------------------------------------------------------------------
module comparator_swap_pipe #(
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_swap_pipe_if.slave bus
);

    // -----------------------------------------------------------------------
    // Handshake control
    // -----------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load;
    logic s2_adv;
    logic in_ready_c;

    assign s2_adv     = s1_valid_q & (~s2_valid_q | bus.out_ready);
    // Held low during reset so nothing is accepted while the pipe clears.
    assign in_ready_c = ~rst & (~s1_valid_q | s2_adv);
    assign s1_load    = bus.in_valid & in_ready_c;

    // -----------------------------------------------------------------------
    // Stage-1 comparison on the incoming operands
    // -----------------------------------------------------------------------
    logic         cmp_lt;
    logic         cmp_eq;
    logic         sgn_a, sgn_b;
    logic [W-2:0] mag_a, mag_b;

    assign sgn_a = bus.Data_A[W-1];
    assign sgn_b = bus.Data_B[W-1];
    assign mag_a = bus.Data_A[W-2:0];
    assign mag_b = bus.Data_B[W-2:0];

    always_comb begin
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        case (MODE)
            1: begin
                cmp_lt = $signed(bus.Data_A) < $signed(bus.Data_B);
                cmp_eq = bus.Data_A == bus.Data_B;
            end
            2: begin
                // +0 and -0 compare equal; otherwise sign decides first,
                // then magnitude (inverted when both are negative).
                if (mag_a == '0 && mag_b == '0) begin
                    cmp_eq = 1'b1;
                end else if (sgn_a != sgn_b) begin
                    cmp_lt = sgn_a;
                end else if (mag_a == mag_b) begin
                    cmp_eq = 1'b1;
                end else if (sgn_a) begin
                    cmp_lt = mag_a > mag_b;
                end else begin
                    cmp_lt = mag_a < mag_b;
                end
            end
            default: begin
                cmp_lt = bus.Data_A < bus.Data_B;
                cmp_eq = bus.Data_A == bus.Data_B;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stage-1 registers
    // -----------------------------------------------------------------------
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         lt_q, lt_d;
    logic         eq_q, eq_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        lt_d       = lt_q;
        eq_d       = eq_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            a_d        = bus.Data_A;
            b_d        = bus.Data_B;
            lt_d       = cmp_lt;
            eq_d       = cmp_eq;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            lt_q       <= lt_d;
            eq_q       <= eq_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage-2 ordering (and optional difference)
    // -----------------------------------------------------------------------
    logic [W-1:0] hi_c, lo_c;

    assign hi_c = lt_q ? b_q : a_q;
    assign lo_c = lt_q ? a_q : b_q;

`ifdef CMP_SWAP_DIFF_EN
    logic [W-1:0] hi_m, lo_m;
    logic [W-1:0] diff_c;

    always_comb begin
        hi_m   = hi_c;
        lo_m   = lo_c;
        diff_c = '0;
        if (MODE == 2) begin
            // Sign-magnitude: subtract the magnitudes only and report the
            // absolute distance, since the larger value can have the
            // smaller magnitude when both are negative.
            hi_m[W-1] = 1'b0;
            lo_m[W-1] = 1'b0;
            diff_c    = (hi_m >= lo_m) ? (hi_m - lo_m) : (lo_m - hi_m);
        end else begin
            diff_c = hi_m - lo_m;
        end
    end

    logic [W-1:0] diff_q, diff_d;
`endif

    logic         less_q, less_d;
    logic         equal_q, equal_d;
    logic         greater_q, greater_d;
    logic         swap_q, swap_d;
    logic [W-1:0] max_q, max_d;
    logic [W-1:0] min_q, min_d;

    always_comb begin
        s2_valid_d = s2_valid_q;
        less_d     = less_q;
        equal_d    = equal_q;
        greater_d  = greater_q;
        swap_d     = swap_q;
        max_d      = max_q;
        min_d      = min_q;
`ifdef CMP_SWAP_DIFF_EN
        diff_d     = diff_q;
`endif
        if (s2_adv) begin
            s2_valid_d = 1'b1;
            less_d     = lt_q;
            equal_d    = eq_q;
            greater_d  = ~lt_q & ~eq_q;
            swap_d     = lt_q;
            max_d      = hi_c;
            min_d      = lo_c;
`ifdef CMP_SWAP_DIFF_EN
            diff_d     = diff_c;
`endif
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            less_q     <= 1'b0;
            equal_q    <= 1'b0;
            greater_q  <= 1'b0;
            swap_q     <= 1'b0;
            max_q      <= '0;
            min_q      <= '0;
`ifdef CMP_SWAP_DIFF_EN
            diff_q     <= '0;
`endif
        end else begin
            s2_valid_q <= s2_valid_d;
            less_q     <= less_d;
            equal_q    <= equal_d;
            greater_q  <= greater_d;
            swap_q     <= swap_d;
            max_q      <= max_d;
            min_q      <= min_d;
`ifdef CMP_SWAP_DIFF_EN
            diff_q     <= diff_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_valid_q;
    assign bus.less      = less_q;
    assign bus.equal     = equal_q;
    assign bus.greater   = greater_q;
    assign bus.swap      = swap_q;
    assign bus.max_out   = max_q;
    assign bus.min_out   = min_q;
`ifdef CMP_SWAP_DIFF_EN
    assign bus.diff_out  = diff_q;
`endif

endmodule

// File: tb/tb_comparator_swap_pipe.sv
// ---------------------------------------------------------------------------
// tb_comparator_swap_pipe
//   Drives one shared stimulus stream into three comparators (MODE 0/1/2) and
//   checks each against a value-level reference model plus an in-flight
//   queue that predicts in_ready, out_valid and result order.
// ---------------------------------------------------------------------------
module tb_comparator_swap_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] da = '0;
    logic [7:0] db = '0;

    always #5 clk = ~clk;

    comparator_swap_pipe_if #(.W(8)) if0 ();
    comparator_swap_pipe_if #(.W(8)) if1 ();
    comparator_swap_pipe_if #(.W(8)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;
    assign if0.Data_A   = da;        assign if0.Data_B    = db;
    assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
    assign if1.Data_A   = da;        assign if1.Data_B    = db;
    assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;
    assign if2.Data_A   = da;        assign if2.Data_B    = db;

    comparator_swap_pipe #(.W(8), .MODE(0)) u_m0 (.clk(clk), .rst(rst), .bus(if0));
    comparator_swap_pipe #(.W(8), .MODE(1)) u_m1 (.clk(clk), .rst(rst), .bus(if1));
    comparator_swap_pipe #(.W(8), .MODE(2)) u_m2 (.clk(clk), .rst(rst), .bus(if2));

    // Observed outputs per mode: {less,equal,greater,swap,max,min,diff}
    logic [7:0]  dif [3];
    logic [27:0] obs [3];
    logic        ov  [3];
    logic        ir  [3];

`ifdef CMP_SWAP_DIFF_EN
    assign dif[0] = if0.diff_out;
    assign dif[1] = if1.diff_out;
    assign dif[2] = if2.diff_out;
`else
    assign dif[0] = '0;
    assign dif[1] = '0;
    assign dif[2] = '0;
`endif

    assign obs[0] = {if0.less, if0.equal, if0.greater, if0.swap, if0.max_out, if0.min_out, dif[0]};
    assign obs[1] = {if1.less, if1.equal, if1.greater, if1.swap, if1.max_out, if1.min_out, dif[1]};
    assign obs[2] = {if2.less, if2.equal, if2.greater, if2.swap, if2.max_out, if2.min_out, dif[2]};
    assign ov[0] = if0.out_valid;  assign ir[0] = if0.in_ready;
    assign ov[1] = if1.out_valid;  assign ir[1] = if1.in_ready;
    assign ov[2] = if2.out_valid;  assign ir[2] = if2.in_ready;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Numeric value of a pattern under each compare mode.
    function automatic int val(input int mode, input logic [7:0] x);
        case (mode)
            1:       return x[7] ? int'(x) - 256 : int'(x);
            2:       return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
            default: return int'(x);
        endcase
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         stamp;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    int          n_out = 0;
    logic        stall_prev = 1'b0;
    logic [27:0] held [3];

    task automatic check_res(input int m, input ent_t e);
        int         va, vb, ma, mb;
        logic       el, ee, eg;
        logic [7:0] emx, emn, edf;
        va  = val(m, e.a);
        vb  = val(m, e.b);
        el  = va < vb;
        ee  = va == vb;
        eg  = va > vb;
        emx = el ? e.b : e.a;
        emn = el ? e.a : e.b;
        if (m == 2) begin
            ma  = int'(e.a[6:0]);
            mb  = int'(e.b[6:0]);
            edf = 8'((ma > mb) ? ma - mb : mb - ma);
        end else begin
            edf = 8'(val(m, emx) - val(m, emn));
        end
        check($sformatf("m%0d less a=%h b=%h", m, e.a, e.b), 32'(obs[m][27]), 32'(el));
        check($sformatf("m%0d equal a=%h b=%h", m, e.a, e.b), 32'(obs[m][26]), 32'(ee));
        check($sformatf("m%0d greater a=%h b=%h", m, e.a, e.b), 32'(obs[m][25]), 32'(eg));
        check($sformatf("m%0d swap a=%h b=%h", m, e.a, e.b), 32'(obs[m][24]), 32'(el));
        check($sformatf("m%0d onehot", m), 32'($countones(obs[m][27:25])), 32'd1);
        check($sformatf("m%0d max a=%h b=%h", m, e.a, e.b), 32'(obs[m][23:16]), 32'(emx));
        check($sformatf("m%0d min a=%h b=%h", m, e.a, e.b), 32'(obs[m][15:8]), 32'(emn));
`ifdef CMP_SWAP_DIFF_EN
        check($sformatf("m%0d diff a=%h b=%h", m, e.a, e.b), 32'(obs[m][7:0]), 32'(edf));
`endif
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, update model.
    task automatic step(input logic r, input logic v, input logic [7:0] a_, input logic [7:0] b_,
                        input logic ordy, output logic acc);
        logic exp_ov, exp_rdy;
        ent_t e;
        @(negedge clk);
        rst = r; in_valid = v; da = a_; db = b_; out_ready = ordy;
        #1;
        acc = 1'b0;
        if (r) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            for (int m = 0; m < 3; m++) begin
                if (stall_prev) begin
                    check($sformatf("m%0d hold valid", m), 32'(ov[m]), 32'd1);
                    check($sformatf("m%0d hold data", m), 32'(obs[m]), 32'(held[m]));
                end
            end
            exp_ov  = (q.size() > 0) && ((cyc - q[0].stamp) >= 2);
            exp_rdy = (q.size() < 2) || ordy;
            for (int m = 0; m < 3; m++) begin
                check($sformatf("m%0d out_valid cyc=%0d", m, cyc), 32'(ov[m]), 32'(exp_ov));
                check($sformatf("m%0d in_ready cyc=%0d", m, cyc), 32'(ir[m]), 32'(exp_rdy));
            end
            if (exp_ov && ordy) begin
                e = q.pop_front();
                n_out++;
                for (int m = 0; m < 3; m++) check_res(m, e);
            end
            if (v && exp_rdy) begin
                q.push_back('{a: a_, b: b_, stamp: cyc});
                acc = 1'b1;
            end
            stall_prev = exp_ov && !ordy;
            for (int m = 0; m < 3; m++) held[m] = obs[m];
        end
        cyc++;
    endtask

    // Single pair, out_ready high, returns at the sample where it is valid.
    task automatic one_pair(input logic [7:0] a_, input logic [7:0] b_);
        logic acc;
        step(1'b0, 1'b1, a_, b_, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    endtask

    logic [7:0] pa [4] = '{8'h10, 8'h90, 8'h7F, 8'h80};
    logic [7:0] pb [4] = '{8'h20, 8'h05, 8'h7F, 8'h00};

    initial begin
        logic       acc;
        int         idx;
        int         acc_n;
        int         t;
        logic [7:0] ra, rb;

        // Reset and idle state
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, acc);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, acc);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, acc);
        for (int m = 0; m < 3; m++)
            check($sformatf("m%0d reset outputs", m), 32'(obs[m]), 32'd0);

        // Unsigned example
        one_pair(8'h12, 8'h34);
        check("t1 out_valid", 32'(ov[0]), 32'd1);
        check("t1 less", 32'(obs[0][27]), 32'd1);
        check("t1 swap", 32'(obs[0][24]), 32'd1);
        check("t1 max", 32'(obs[0][23:16]), 32'h34);
        check("t1 min", 32'(obs[0][15:8]), 32'h12);
`ifdef CMP_SWAP_DIFF_EN
        check("t1 diff", 32'(obs[0][7:0]), 32'h22);
`endif

        // Two's complement examples
        one_pair(8'hFF, 8'h01);
        check("t2 less", 32'(obs[1][27]), 32'd1);
        check("t2 max", 32'(obs[1][23:16]), 32'h01);
        check("t2 min", 32'(obs[1][15:8]), 32'hFF);
        one_pair(8'h80, 8'h7F);
        check("t2 less min-max", 32'(obs[1][27]), 32'd1);
        one_pair(8'h7F, 8'h7F);
        check("t2 equal", 32'(obs[1][26]), 32'd1);
        check("t2 swap", 32'(obs[1][24]), 32'd0);
        check("t2 max eq", 32'(obs[1][23:16]), 32'h7F);
        check("t2 min eq", 32'(obs[1][15:8]), 32'h7F);

        // Sign-magnitude examples
        one_pair(8'h80, 8'h00);
        check("t3 -0 == +0", 32'(obs[2][26]), 32'd1);
        check("t3 -0 max raw", 32'(obs[2][23:16]), 32'h80);
        one_pair(8'h85, 8'h83);
        check("t3 less", 32'(obs[2][27]), 32'd1);
        check("t3 max", 32'(obs[2][23:16]), 32'h83);
`ifdef CMP_SWAP_DIFF_EN
        check("t3 diff", 32'(obs[2][7:0]), 32'h02);
`endif
        one_pair(8'h05, 8'h83);
        check("t3 greater", 32'(obs[2][25]), 32'd1);

        // Backpressure: four pairs, out_ready low for five cycles
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            ra = (idx < 4) ? pa[idx] : 8'h00;
            rb = (idx < 4) ? pb[idx] : 8'h00;
            step(1'b0, idx < 4, ra, rb, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp accepts while stalled", 32'(idx), 32'd2);
        check("bp in_ready low", 32'(ir[0]), 32'd0);
        n_out = 0;
        t = 0;
        while ((idx < 4 || q.size() > 0) && t < 30) begin
            ra = (idx < 4) ? pa[idx] : 8'h00;
            rb = (idx < 4) ? pb[idx] : 8'h00;
            step(1'b0, idx < 4, ra, rb, 1'b1, acc);
            if (acc) idx++;
            t++;
        end
        check("bp drain within budget", 32'(t < 30), 32'd1);
        check("bp results delivered", 32'(n_out), 32'd4);

        // Reset with two results in flight
        step(1'b0, 1'b1, 8'h11, 8'h22, 1'b0, acc);
        step(1'b0, 1'b1, 8'h33, 8'h44, 1'b0, acc);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, acc);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
        check("rst out_valid", 32'(ov[0]), 32'd0);
        check("rst in_ready", 32'(ir[0]), 32'd1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);

        // Random traffic with corner-value bias
        acc_n = 0;
        t = 0;
        while (acc_n < 10000 && t < 40000) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = ra;
                1:       rb = ra ^ 8'h80;
                2:       rb = 8'h00;
                3:       rb = 8'h80;
                default: rb = 8'($urandom);
            endcase
            step(1'b0, $urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0, acc);
            if (acc) acc_n++;
            t++;
        end
        check("random accept budget", 32'(acc_n), 32'd10000);
        t = 0;
        while (q.size() > 0 && t < 10) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
            t++;
        end
        check("random drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
